// File: rtl/rhs_op_pkg.sv
// rhs_op_pkg: opcode encoding shared by the RHS-operation pipeline and its ALU
package rhs_op_pkg;
    typedef enum logic [2:0] {
        OP_ADD,
        OP_MIX,
        OP_EQ,
        OP_MUX,
        OP_CAT,
        OP_REPL,
        OP_RED,
        OP_ACC
    } rhs_op_e;
endpackage

// File: rtl/rhs_op_alu.sv
// rhs_op_alu: combinational evaluation of one RHS operation, including the accumulator step
module rhs_op_alu
    import rhs_op_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  rhs_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic             sel_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] data_o,
    output logic             flag_o,
    output logic [WIDTH-1:0] acc_next_o,
    output logic             acc_we_o
);
    localparam int H = WIDTH / 2;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] acc_sum;
    // Result, side flag and accumulator update for the selected opcode
    always_comb begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        acc_sum    = {1'b0, acc_i} + {1'b0, a_i};
        data_o     = '0;
        flag_o     = 1'b0;
        acc_next_o = acc_i;
        acc_we_o   = 1'b0;
        case (op_i)
            OP_ADD:  {flag_o, data_o} = sum;
            OP_MIX: begin
                data_o = (a_i - b_i) ^ ~c_i;
                flag_o = a_i < b_i;
            end
            OP_EQ:   flag_o = (a_i == b_i) && sel_i;
            OP_MUX:  data_o = sel_i ? a_i : b_i;
            OP_CAT:  data_o = {a_i[H-1:0], b_i[H-1:0]};
            OP_REPL: begin
                data_o = {WIDTH{sel_i}};
                flag_o = sel_i;
            end
            OP_RED: begin
                data_o = WIDTH'({~&a_i, |a_i, ^a_i});
                flag_o = &a_i;
            end
            OP_ACC: begin
                acc_we_o   = 1'b1;
                acc_next_o = sel_i ? ACC_INIT : acc_sum[WIDTH-1:0];
                data_o     = acc_next_o;
                flag_o     = !sel_i && acc_sum[WIDTH];
            end
        endcase
    end
endmodule

// File: rtl/rhs_op_pipe.sv
// rhs_op_pipe: two-stage valid/ready pipeline applying one RHS operation per transaction
module rhs_op_pipe
    import rhs_op_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_flag
);
    typedef struct packed {
        rhs_op_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             sel;
    } rhs_req_t;

    rhs_req_t         req_q, req_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_flag_q, out_flag_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_data, alu_acc_next;
    logic             alu_flag, alu_acc_we;
    logic             s2_free, s1_move;

    assign s2_free   = !out_valid_q || out_ready;
    assign s1_move   = s1_valid_q && s2_free;
    assign in_ready  = !s1_valid_q || s2_free;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flag  = out_flag_q;

    rhs_op_alu #(.WIDTH(WIDTH), .ACC_INIT(ACC_INIT)) u_alu (
        .op_i      (req_q.op),
        .a_i       (req_q.a),
        .b_i       (req_q.b),
        .c_i       (req_q.c),
        .sel_i     (req_q.sel),
        .acc_i     (acc_q),
        .data_o    (alu_data),
        .flag_o    (alu_flag),
        .acc_next_o(alu_acc_next),
        .acc_we_o  (alu_acc_we)
    );

    // Stage loads: S1 takes new requests, S2 takes the ALU result when S1 advances
    always_comb begin
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        req_d       = (in_valid && in_ready) ? '{op: rhs_op_e'(in_op), a: in_a, b: in_b, c: in_c, sel: in_sel} : req_q;
        out_valid_d = s2_free ? s1_valid_q : out_valid_q;
        out_data_d  = s1_move ? alu_data : out_data_q;
        out_flag_d  = s1_move ? alu_flag : out_flag_q;
        acc_d       = (s1_move && alu_acc_we) ? alu_acc_next : acc_q;
    end

    // Pipeline and accumulator registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flag_q  <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            req_q       <= req_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flag_q  <= out_flag_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_rhs_op_pipe.sv
// tb_rhs_op_pipe: directed vector table, multi-cycle corner sequences and a random scoreboard run
module tb_rhs_op_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid, in_ready, in_sel, out_valid, out_ready, out_flag;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b, in_c, out_data;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, c;
        logic       sel;
        logic [7:0] d;
        logic       f;
    } vec_t;

    vec_t tbl[15];
    vec_t bp[4];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rhs_op_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flag(out_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic sel, input logic [7:0] d, input logic f);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.sel = sel; v.d = d; v.f = f;
        return v;
    endfunction

    task automatic model(inout vec_t v, inout logic [7:0] acc);
        int s;
        int ia = int'(v.a);
        int ib = int'(v.b);
        int ic = int'(v.c);
        v.d = 8'h00;
        v.f = 1'b0;
        case (v.op)
            3'd0: begin s = ia + ib; v.d = 8'(s); v.f = s > 255; end
            3'd1: begin v.d = 8'((ia - ib) ^ (255 - ic)); v.f = ia < ib; end
            3'd2: v.f = (ia == ib) && v.sel;
            3'd3: v.d = v.sel ? v.a : v.b;
            3'd4: v.d = {v.a[3:0], v.b[3:0]};
            3'd5: begin v.d = v.sel ? 8'hFF : 8'h00; v.f = v.sel; end
            3'd6: begin v.d = {5'b0, v.a != 8'hFF, v.a != 8'h00, ^v.a}; v.f = v.a == 8'hFF; end
            default: begin
                if (v.sel) acc = 8'h00;
                else begin s = int'(acc) + ia; acc = 8'(s); v.f = s > 255; end
                v.d = acc;
            end
        endcase
    endtask

    task automatic drive(input vec_t v);
        in_op = v.op; in_a = v.a; in_b = v.b; in_c = v.c; in_sel = v.sel;
    endtask

    task automatic send(input vec_t v);
        bit done = 0;
        drive(v);
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0d", v.op);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation
    always @(negedge clk) begin
        vec_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out: got data 0x%0h with no transaction outstanding", out_data);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("data_op%0d_a%0h", e.op, e.a), int'(out_data), int'(e.d));
                check($sformatf("flag_op%0d_a%0h", e.op, e.a), int'(out_flag), int'(e.f));
            end
        end
    end

    initial begin
        int         idx, sent;
        bit         took, pending;
        logic [7:0] acc_m;
        vec_t       rv;
        in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_sel = 1'b0;
        tbl[0]  = mk(3'd0, 8'd200, 8'd100, 8'h00, 1'b0, 8'd44, 1'b1);
        tbl[1]  = mk(3'd0, 8'd1,   8'd2,   8'h00, 1'b0, 8'd3,  1'b0);
        tbl[2]  = mk(3'd1, 8'd10,  8'd3,   8'hF0, 1'b0, 8'h08, 1'b0);
        tbl[3]  = mk(3'd1, 8'd3,   8'd10,  8'h00, 1'b0, 8'h06, 1'b1);
        tbl[4]  = mk(3'd2, 8'h55,  8'h55,  8'h00, 1'b1, 8'h00, 1'b1);
        tbl[5]  = mk(3'd2, 8'h55,  8'h55,  8'h00, 1'b0, 8'h00, 1'b0);
        tbl[6]  = mk(3'd2, 8'h55,  8'h54,  8'h00, 1'b1, 8'h00, 1'b0);
        tbl[7]  = mk(3'd3, 8'hAA,  8'h55,  8'h00, 1'b1, 8'hAA, 1'b0);
        tbl[8]  = mk(3'd3, 8'hAA,  8'h55,  8'h00, 1'b0, 8'h55, 1'b0);
        tbl[9]  = mk(3'd4, 8'h12,  8'h34,  8'h00, 1'b0, 8'h24, 1'b0);
        tbl[10] = mk(3'd5, 8'h00,  8'h00,  8'h00, 1'b1, 8'hFF, 1'b1);
        tbl[11] = mk(3'd5, 8'hFF,  8'hFF,  8'hFF, 1'b0, 8'h00, 1'b0);
        tbl[12] = mk(3'd6, 8'hFF,  8'h00,  8'h00, 1'b0, 8'h02, 1'b1);
        tbl[13] = mk(3'd6, 8'h00,  8'h00,  8'h00, 1'b0, 8'h04, 1'b0);
        tbl[14] = mk(3'd6, 8'h07,  8'h00,  8'h00, 1'b0, 8'h07, 1'b0);
        for (int i = 0; i < 4; i++) bp[i] = mk(3'd3, 8'(8'h10 + i), 8'h00, 8'h00, 1'b1, 8'(8'h10 + i), 1'b0);

        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_flag", int'(out_flag), 0);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);

        drive(tbl[0]);
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", int'(in_ready), 1);
        exp_q.push_back(tbl[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_after_1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_after_2", int'(out_valid), 1);
        drain();

        for (int i = 1; i < 15; i++) send(tbl[i]);
        drain();

        send(mk(3'd7, 8'd5, 8'h00, 8'h00, 1'b0, 8'd5, 1'b0));
        send(mk(3'd7, 8'd6, 8'h00, 8'h00, 1'b0, 8'd11, 1'b0));
        send(mk(3'd7, 8'd7, 8'h00, 8'h00, 1'b0, 8'd18, 1'b0));
        send(mk(3'd7, 8'd9, 8'h00, 8'h00, 1'b1, 8'd0, 1'b0));
        send(mk(3'd7, 8'd0, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0));
        send(mk(3'd7, 8'd250, 8'h00, 8'h00, 1'b0, 8'd250, 1'b0));
        send(mk(3'd7, 8'd10, 8'h00, 8'h00, 1'b0, 8'd4, 1'b1));
        send(mk(3'd7, 8'd0, 8'h00, 8'h00, 1'b1, 8'd0, 1'b0));
        drain();

        out_ready = 1'b0;
        idx = 0;
        drive(bp[0]);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            took = 0;
            @(negedge clk);
            if (in_ready && idx < 4) begin
                exp_q.push_back(bp[idx]);
                took = 1;
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                drive(bp[idx]);
            end
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready_full", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_head_data", int'(out_data), 8'h10);
        repeat (3) @(posedge clk);
        #1;
        check("bp_held_data", int'(out_data), 8'h10);
        check("bp_still_full", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp_nogap_%0d", k), int'(out_valid), 1);
            if (in_valid && in_ready) begin
                exp_q.push_back(bp[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) drive(bp[idx]);
            else in_valid = 1'b0;
        end
        check("bp_all_sent", idx, 4);
        drain();

        send(mk(3'd7, 8'd0, 8'h00, 8'h00, 1'b1, 8'd0, 1'b0));
        send(mk(3'd7, 8'd5, 8'h00, 8'h00, 1'b0, 8'd5, 1'b0));
        send(mk(3'd7, 8'd6, 8'h00, 8'h00, 1'b0, 8'd11, 1'b0));
        send(mk(3'd7, 8'd7, 8'h00, 8'h00, 1'b0, 8'd18, 1'b0));
        drain();
        out_ready = 1'b0;
        send(mk(3'd0, 8'd1, 8'd1, 8'h00, 1'b0, 8'd2, 1'b0));
        send(mk(3'd7, 8'd2, 8'h00, 8'h00, 1'b0, 8'd20, 1'b0));
        in_valid = 1'b0;
        check("rstp_full", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstp_out_valid_async", int'(out_valid), 0);
        check("rstp_out_data_async", int'(out_data), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("rstp_in_ready", int'(in_ready), 1);
        send(mk(3'd7, 8'd1, 8'h00, 8'h00, 1'b0, 8'd1, 1'b0));
        drain();

        acc_m = 8'd1;
        sent = 0;
        pending = 0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            if (!pending) begin
                rv = mk(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'h00, 1'b0);
                model(rv, acc_m);
                pending = 1;
            end
            drive(rv);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(rv);
                sent++;
                pending = 0;
            end
            @(posedge clk); #1;
        end
        check("rand_sent", sent, 10000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
